tdm_demux: RTL
==============

TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 Parameter N_CH, default 8, meaning number of 1-bit channel slots per frame (legal 2..16).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 resetn  input  1  reset, asynchronous, active-low.
REQ-004 din  input  1  serial TDM bit stream, one slot bit per clk.
REQ-005 sync  input  1  frame-start strobe; high in the cycle din carries slot 0.
REQ-006 data_out  output  N_CH  last completed frame, bit i = slot i.
REQ-007 out_valid  output  1  data_out holds an unconsumed frame.
REQ-008 out_ready  input  1  consumer accepts data_out when high with out_valid.
REQ-009 overrun  output  1  sticky; a completed frame was dropped.
REQ-010 resync  output  1  one-cycle pulse; sync arrived mid-frame.
REQ-011 parity_err  output  1  parity flag qualified by out_valid (see Configuration).

Function
REQ-012 FSM states SHALL be IDLE, RECV, PAR (PAR exists only with TDM_PARITY_EN).
REQ-013 IDLE: din ignored unless sync=1; on sync, din captured into slot 0, slot counter set to 1, go RECV.
REQ-014 RECV: each cycle din captured into slot[cnt], cnt increments.
REQ-015 On capture of slot N_CH-1: go PAR if enabled, else frame complete and return to IDLE.
REQ-016 Back-to-back frames: sync in the cycle after the last bit (frame or parity) SHALL be accepted with no gap cycle.
REQ-017 sync=1 while in RECV or PAR: partial frame discarded, din captured as slot 0, cnt=1, resync pulses for that cycle, state RECV.
REQ-018 Frame complete: data_out loaded and out_valid=1 on the edge after the last bit is sampled (latency 1 cycle from last bit).
REQ-019 out_valid & out_ready on an edge clears out_valid unless a frame completes on the same edge, in which case the new frame loads and out_valid stays 1.
REQ-020 Frame completes while out_valid=1 and out_ready=0: new frame dropped, data_out unchanged, overrun set and held until reset.
REQ-021 data_out SHALL not change while out_valid=1 and out_ready=0.
REQ-022 Slot counter width $clog2(N_CH); no wrap beyond N_CH-1.

Reset
REQ-023 resetn low SHALL immediately force: state IDLE, cnt 0, data_out 0, out_valid 0, overrun 0, resync 0, parity_err 0.
REQ-024 Reset mid-frame discards the partial frame; first frame after reset requires a new sync.

Configuration
REQ-025 Macro TDM_PARITY_EN defined: each frame carries one extra even-parity bit after slot N_CH-1, sampled in PAR; parity_err = (XOR of data bits) != parity bit, loaded alongside data_out; frame delivered regardless.
REQ-026 TDM_PARITY_EN undefined: frame is N_CH bits, PAR state absent, parity_err tied 0, port retained.

Structure
REQ-027 Package tdm_pkg SHALL hold the state enum type and the default N_CH constant.
REQ-028 One sub-module tdm_slot_counter (load-to-1 on sync, increment, terminal-count flag) is natural; shift/capture, FSM and output register stay in tdm_demux.

Verification
REQ-029 Reset then sync with din sequence 1,0,1,1,0,0,1,0 (N_CH=8, no parity), out_ready=1 -> data_out=8'b0100_1101, out_valid one cycle after bit 7.
REQ-030 Two back-to-back frames 0xA5 then 0x3C, out_ready=0 until after second -> data_out stays 0xA5, overrun=1.
REQ-031 Sync asserted at slot 4 of a frame -> resync pulse one cycle, following 8 bits 0xFF form data_out=0xFF, no partial frame output.
REQ-032 resetn low at slot 3 then released, bits without sync -> out_valid stays 0; subsequent sync frame 0x81 delivered.
REQ-033 With TDM_PARITY_EN, frame 0x07 with parity 1 -> parity_err=0; parity 0 -> parity_err=1, data_out=0x07 both times.
REQ-034 Frame completes on the same edge as out_ready accepts prior frame -> out_valid remains 1, data_out shows new frame, overrun stays 0.

Source files
------------

// File: rtl/tdm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tdm_pkg
//  Purpose  : Shared types and constants for the TDM demultiplexer.
//             The PAR state exists only when TDM_PARITY_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
package tdm_pkg;

  // Default number of 1-bit slots per frame
  localparam int TDM_N_CH_DEFAULT = 8;

  // Frame receiver states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1
`ifdef TDM_PARITY_EN
    ,
    PAR  = 2'd2
`endif
  } tdm_state_t;

endpackage
`default_nettype wire

// File: rtl/tdm_slot_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tdm_slot_counter
//  Purpose  : Slot index within the current frame. Loads 1 on frame start
//             (slot 0 is captured in that same cycle), increments per slot,
//             saturates at N_CH-1 and flags the terminal slot.
//  Revision : 1.0 - initial release
// ============================================================================
module tdm_slot_counter #(
  parameter int N_CH = 8
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    i_load,
  input  logic                    i_inc,
  input  logic                    i_clr,
  output logic [$clog2(N_CH)-1:0] o_cnt,
  output logic                    o_tc
);

  localparam int CW = $clog2(N_CH);

  logic [CW-1:0] r_cnt;
  logic          w_tc;

  // Terminal count: the slot currently being captured is the last data slot
  assign w_tc = (r_cnt == CW'(N_CH - 1));

  // Counter register: load wins over clear, increment never wraps
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CW'(1);
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !w_tc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = w_tc;

endmodule
`default_nettype wire

// File: rtl/tdm_demux.sv
`default_nettype none
// ============================================================================
//  Module   : tdm_demux
//  Purpose  : Serial TDM bit stream to parallel frame demultiplexer with a
//             one-deep valid/ready output register, sticky overrun and a
//             resync pulse when a frame start interrupts a partial frame.
//  Options  : TDM_PARITY_EN - each frame carries a trailing even-parity bit,
//             checked into parity_err alongside data_out.
//  Revision : 1.0 - initial release
// ============================================================================
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int N_CH = TDM_N_CH_DEFAULT
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            din,
  input  logic            sync,
  input  logic            out_ready,
  output logic [N_CH-1:0] data_out,
  output logic            out_valid,
  output logic            overrun,
  output logic            resync,
  output logic            parity_err
);

  localparam int CW = $clog2(N_CH);

  tdm_state_t      r_state;
  tdm_state_t      w_state_nxt;
  logic            w_cnt_load;
  logic            w_cnt_inc;
  logic            w_cnt_clr;
  logic            w_cnt_tc;
  logic [CW-1:0]   w_cnt;
  logic            w_done;
  logic            w_resync;
  logic [N_CH-1:0] r_frame;
  logic [N_CH-1:0] w_frame_cap;
  logic [N_CH-1:0] w_done_data;
  logic [N_CH-1:0] r_data_out;
  logic            r_out_valid;
  logic            r_overrun;

  tdm_slot_counter #(
    .N_CH (N_CH)
  ) u_slot_counter (
    .clk    (clk),
    .resetn (resetn),
    .i_load (w_cnt_load),
    .i_inc  (w_cnt_inc),
    .i_clr  (w_cnt_clr),
    .o_cnt  (w_cnt),
    .o_tc   (w_cnt_tc)
  );

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, counter control, frame-done and resync decode
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_load  = 1'b0;
    w_cnt_inc   = 1'b0;
    w_cnt_clr   = 1'b0;
    w_done      = 1'b0;
    w_resync    = 1'b0;
    case (r_state)
      IDLE: begin
        if (sync) begin
          w_cnt_load  = 1'b1;
          w_state_nxt = RECV;
        end
      end
      RECV: begin
        if (sync) begin
          w_cnt_load  = 1'b1;
          w_resync    = 1'b1;
          w_state_nxt = RECV;
        end else if (w_cnt_tc) begin
          w_cnt_clr   = 1'b1;
`ifdef TDM_PARITY_EN
          w_state_nxt = PAR;
`else
          w_done      = 1'b1;
          w_state_nxt = IDLE;
`endif
        end else begin
          w_cnt_inc   = 1'b1;
        end
      end
`ifdef TDM_PARITY_EN
      PAR: begin
        if (sync) begin
          w_cnt_load  = 1'b1;
          w_resync    = 1'b1;
          w_state_nxt = RECV;
        end else begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
`endif
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Current frame with this cycle's bit dropped into the addressed slot
  always_comb begin
    w_frame_cap        = r_frame;
    w_frame_cap[w_cnt] = din;
  end

  // Frame assembly: a frame start clears stale slots from any partial frame
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_frame <= '0;
    end else if (w_cnt_load) begin
      r_frame <= {{(N_CH-1){1'b0}}, din};
    end else if (r_state == RECV) begin
      r_frame <= w_frame_cap;
    end
  end

`ifdef TDM_PARITY_EN
  logic w_done_perr;
  logic r_perr;

  // Data is complete in r_frame by the time the parity bit arrives
  assign w_done_data = r_frame;
  assign w_done_perr = (^r_frame) ^ din;

  // Parity flag travels with the delivered frame
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_perr <= 1'b0;
    end else if (w_done && (!r_out_valid || out_ready)) begin
      r_perr <= w_done_perr;
    end
  end

  assign parity_err = r_perr & r_out_valid;
`else
  // Last data bit is still on din when the frame completes
  assign w_done_data = w_frame_cap;
  assign parity_err  = 1'b0;
`endif

  // Output register: load on completion when empty or being drained,
  // otherwise the new frame is dropped and overrun latches
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_data_out  <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (w_done) begin
      if (!r_out_valid || out_ready) begin
        r_data_out  <= w_done_data;
        r_out_valid <= 1'b1;
      end else begin
        r_overrun   <= 1'b1;
      end
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign data_out  = r_data_out;
  assign out_valid = r_out_valid;
  assign overrun   = r_overrun;
  assign resync    = w_resync;

endmodule
`default_nettype wire
